// File: rtl/wb_arbiter.sv
// Writeback arbiter: grants the single register-file write port to one of NREQ
// pipelines per cycle (starved > hipri > round-robin) and registers the write.
module wb_arbiter #(
  parameter int NREQ         = 4,
  parameter int STARVE_LIMIT = 8,
  parameter int CNT_W        = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ-1:0]      req_hipri,
  input  logic [5*NREQ-1:0]    req_dst,
  input  logic [NREQ-1:0]      req_wb_en,
  input  logic [64*NREQ-1:0]   req_result,
  input  logic [64*NREQ-1:0]   req_pc,
  output logic                 rf_wen,
  output logic [4:0]           rf_waddr,
  output logic [63:0]          rf_wdata,
  output logic                 wb_valid,
  output logic [63:0]          wb_pc,
  output logic [2:0]           wb_src,
  output logic [CNT_W-1:0]     retire_count
);

  localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int SC_W  = $clog2(STARVE_LIMIT + 1);
  localparam logic [SC_W-1:0] SC_MAX = SC_W'(STARVE_LIMIT);

  logic [PTR_W-1:0]  r_rr_ptr;
  logic [SC_W-1:0]   r_starve [NREQ];
  logic              r_rf_wen;
  logic [4:0]        r_rf_waddr;
  logic [63:0]       r_rf_wdata;
  logic              r_wb_valid;
  logic [63:0]       r_wb_pc;
  logic [2:0]        r_wb_src;
  logic [CNT_W-1:0]  r_retire_count;

  logic [NREQ-1:0]   w_starved;
  logic [NREQ-1:0]   w_hipri;
  logic [NREQ-1:0]   w_req_ready;
  logic [2:0]        w_gnt_idx;
  logic              w_gnt_any;
  logic              w_gnt_rr;
  logic [4:0]        w_sel_dst;
  logic              w_sel_wb_en;
  logic [63:0]       w_sel_result;
  logic [63:0]       w_sel_pc;

  // Classify each requester into the starved and hipri tiers
  always_comb begin
    w_starved = '0;
    w_hipri   = '0;
    for (int i = 0; i < NREQ; i++) begin
      w_starved[i] = req_valid[i] && (r_starve[i] >= SC_MAX);
      w_hipri[i]   = req_valid[i] && req_hipri[i];
    end
  end

  // Pick the winner; loops run high-to-low so the lowest index/offset sticks
  always_comb begin
    w_gnt_idx = 3'd0;
    w_gnt_any = 1'b0;
    w_gnt_rr  = 1'b0;
    if (|w_starved) begin
      w_gnt_any = 1'b1;
      for (int i = NREQ-1; i >= 0; i--)
        w_gnt_idx = w_starved[i] ? 3'(i) : w_gnt_idx;
    end else if (|w_hipri) begin
      w_gnt_any = 1'b1;
      for (int i = NREQ-1; i >= 0; i--)
        w_gnt_idx = w_hipri[i] ? 3'(i) : w_gnt_idx;
    end else if (|req_valid) begin
      w_gnt_any = 1'b1;
      w_gnt_rr  = 1'b1;
      for (int j = NREQ-1; j >= 0; j--)
        w_gnt_idx = req_valid[(int'(r_rr_ptr) + j) % NREQ] ?
                    3'((int'(r_rr_ptr) + j) % NREQ) : w_gnt_idx;
    end else begin
      w_gnt_any = 1'b0;
    end
  end

  // One-hot ready, forced low while reset is asserted; payload mux for the winner
  always_comb begin
    w_req_ready  = '0;
    w_sel_dst    = 5'd0;
    w_sel_wb_en  = 1'b0;
    w_sel_result = 64'd0;
    w_sel_pc     = 64'd0;
    for (int i = 0; i < NREQ; i++) begin
      w_req_ready[i] = rst && w_gnt_any && (int'(w_gnt_idx) == i);
      if (int'(w_gnt_idx) == i) begin
        w_sel_dst    = req_dst[5*i +: 5];
        w_sel_wb_en  = req_wb_en[i];
        w_sel_result = req_result[64*i +: 64];
        w_sel_pc     = req_pc[64*i +: 64];
      end else begin
        w_sel_dst    = w_sel_dst;
      end
    end
  end

  assign req_ready = w_req_ready;

  // Round-robin pointer advances only on round-robin-tier grants
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rr_ptr <= '0;
    end else if (w_gnt_any && w_gnt_rr) begin
      r_rr_ptr <= (int'(w_gnt_idx) == NREQ-1) ? PTR_W'(0) : PTR_W'(int'(w_gnt_idx) + 1);
    end else begin
      r_rr_ptr <= r_rr_ptr;
    end
  end

  // Per-requester starvation counters, saturating at the limit
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NREQ; i++) r_starve[i] <= '0;
    end else begin
      for (int i = 0; i < NREQ; i++) begin
        if (req_valid[i] && !w_req_ready[i])
          r_starve[i] <= (r_starve[i] >= SC_MAX) ? SC_MAX : r_starve[i] + SC_W'(1);
        else
          r_starve[i] <= '0;
      end
    end
  end

  // Registered writeback stage; payload holds when nothing is granted
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rf_wen   <= 1'b0;
      r_rf_waddr <= 5'd0;
      r_rf_wdata <= 64'd0;
      r_wb_valid <= 1'b0;
      r_wb_pc    <= 64'd0;
      r_wb_src   <= 3'd0;
    end else if (w_gnt_any) begin
      r_wb_valid <= 1'b1;
      r_rf_wen   <= w_sel_wb_en && (w_sel_dst != 5'd0);
      r_rf_waddr <= w_sel_dst;
      r_rf_wdata <= w_sel_result;
      r_wb_pc    <= w_sel_pc;
      r_wb_src   <= w_gnt_idx;
    end else begin
      r_wb_valid <= 1'b0;
      r_rf_wen   <= 1'b0;
    end
  end

  // Retire counter counts registered retirements
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_retire_count <= '0;
    end else if (r_wb_valid) begin
      r_retire_count <= r_retire_count + CNT_W'(1);
    end else begin
      r_retire_count <= r_retire_count;
    end
  end

  assign rf_wen       = r_rf_wen;
  assign rf_waddr     = r_rf_waddr;
  assign rf_wdata     = r_rf_wdata;
  assign wb_valid     = r_wb_valid;
  assign wb_pc        = r_wb_pc;
  assign wb_src       = r_wb_src;
  assign retire_count = r_retire_count;

endmodule

// File: tb/tb_wb_arbiter.sv
// Scoreboard bench for wb_arbiter: the driver queues the expected writeback
// for each grant, a negedge monitor pops and compares whenever wb_valid is high.
module tb_wb_arbiter;

  logic          clk = 1'b0;
  logic          rst;
  logic [3:0]    req_valid;
  logic [3:0]    req_ready;
  logic [3:0]    req_hipri;
  logic [19:0]   req_dst;
  logic [3:0]    req_wb_en;
  logic [255:0]  req_result;
  logic [255:0]  req_pc;
  logic          rf_wen;
  logic [4:0]    rf_waddr;
  logic [63:0]   rf_wdata;
  logic          wb_valid;
  logic [63:0]   wb_pc;
  logic [2:0]    wb_src;
  logic [63:0]   retire_count;

  logic [4:0]    dst_t  [4];
  logic [63:0]   res_t  [4];
  logic [63:0]   pc_t   [4];
  logic          wben_t [4];

  typedef struct {
    logic [2:0]  src;
    logic        wen;
    logic [4:0]  waddr;
    logic [63:0] wdata;
    logic [63:0] pc;
  } exp_t;

  exp_t sb[$];
  int n_vec = 0;
  int n_err = 0;

  wb_arbiter #(.NREQ(4), .STARVE_LIMIT(8), .CNT_W(64)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_hipri(req_hipri),
    .req_dst(req_dst), .req_wb_en(req_wb_en), .req_result(req_result), .req_pc(req_pc),
    .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .wb_valid(wb_valid), .wb_pc(wb_pc), .wb_src(wb_src), .retire_count(retire_count)
  );

  always #5 clk = ~clk;

  always_comb begin
    req_dst    = '0;
    req_wb_en  = '0;
    req_result = '0;
    req_pc     = '0;
    for (int i = 0; i < 4; i++) begin
      req_dst[5*i +: 5]     = dst_t[i];
      req_wb_en[i]          = wben_t[i];
      req_result[64*i +: 64] = res_t[i];
      req_pc[64*i +: 64]     = pc_t[i];
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Called at posedge+1: drive one cycle, check ready, queue the expected writeback.
  task automatic step(input logic [3:0] v, input logic [3:0] h, input int g);
    logic [3:0] exp_rdy;
    exp_t e;
    req_valid = v;
    req_hipri = h;
    @(negedge clk);
    exp_rdy = (g >= 0) ? (4'b0001 << g) : 4'b0000;
    chk("req_ready", 64'(req_ready), 64'(exp_rdy));
    if (g >= 0) begin
      e.src   = 3'(g);
      e.wen   = wben_t[g] && (dst_t[g] != 5'd0);
      e.waddr = dst_t[g];
      e.wdata = res_t[g];
      e.pc    = pc_t[g];
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst === 1'b1 && wb_valid === 1'b1) begin
      n_vec++;
      if (sb.size() == 0) begin
        n_err++;
        $display("FAIL wb_unexpected actual src=%0d required none", wb_src);
      end else begin
        e = sb.pop_front();
        if (wb_src !== e.src || rf_wen !== e.wen || rf_waddr !== e.waddr ||
            rf_wdata !== e.wdata || wb_pc !== e.pc) begin
          n_err++;
          $display("FAIL writeback actual src=%0d wen=%b addr=%0d data=%0h pc=%0h required src=%0d wen=%b addr=%0d data=%0h pc=%0h",
                   wb_src, rf_wen, rf_waddr, rf_wdata, wb_pc,
                   e.src, e.wen, e.waddr, e.wdata, e.pc);
        end
      end
    end else if (rst === 1'b1 && rf_wen !== 1'b0) begin
      n_vec++;
      n_err++;
      $display("FAIL rf_wen_without_wb actual=%b required=0", rf_wen);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  int rr_seq[8]      = '{0, 1, 2, 3, 0, 1, 2, 3};
  int starve_seq[19] = '{1, 1, 1, 1, 1, 1, 1, 1, 2, 3, 1, 1, 1, 1, 1, 1, 1, 2, 3};

  initial begin
    for (int i = 0; i < 4; i++) begin
      dst_t[i]  = 5'(i + 1);
      res_t[i]  = 64'h1111_0000 + 64'(i);
      pc_t[i]   = 64'h8000_0000 + 64'(4 * i);
      wben_t[i] = 1'b1;
    end
    wben_t[3] = 1'b0;
    rst = 1'b1;
    req_valid = 4'b0000;
    req_hipri = 4'b0000;

    // Reset with every requester valid
    #1 rst = 1'b0;
    req_valid = 4'b1111;
    #1;
    chk("rst_ready", 64'(req_ready), 64'd0);
    chk("rst_rf_wen", 64'(rf_wen), 64'd0);
    chk("rst_wb_valid", 64'(wb_valid), 64'd0);
    chk("rst_retire", retire_count, 64'd0);
    @(posedge clk);
    #1;
    chk("rst_edge_wb_valid", 64'(wb_valid), 64'd0);
    chk("rst_edge_ready", 64'(req_ready), 64'd0);
    rst = 1'b1;

    // Round-robin over all four
    foreach (rr_seq[i]) step(4'b1111, 4'b0000, rr_seq[i]);
    step(4'b0000, 4'b0000, -1);
    @(negedge clk);
    chk("retire_after_rr", retire_count, 64'd8);
    @(posedge clk);
    #1;

    // Hipri preempt, pointer must still be 0 afterwards
    step(4'b0101, 4'b0100, 2);
    step(4'b1001, 4'b0000, 0);
    step(4'b0000, 4'b0000, -1);

    // Starvation under continuous hipri from requesters 1 and 3
    foreach (starve_seq[i]) step(4'b1110, 4'b1010, starve_seq[i]);
    step(4'b0000, 4'b0000, -1);

    // Write to x0 retires without a register write
    dst_t[0] = 5'd0;
    res_t[0] = 64'hDEAD;
    step(4'b0001, 4'b0000, 0);
    step(4'b0000, 4'b0000, -1);
    chk("x0_hold_wb_valid", 64'(wb_valid), 64'd0);
    chk("x0_hold_waddr", 64'(rf_waddr), 64'd0);
    chk("x0_hold_wdata", rf_wdata, 64'hDEAD);
    chk("retire_after_x0", retire_count, 64'd30);
    dst_t[0] = 5'd1;
    res_t[0] = 64'h1111_0000;

    // Async reset in the middle of a stream
    step(4'b1111, 4'b0000, 1);
    step(4'b1111, 4'b0000, 2);
    #1;
    chk("mid_pre_wb_valid", 64'(wb_valid), 64'd1);
    chk("mid_pre_ready", 64'(req_ready), 64'(4'b1000));
    rst = 1'b0;
    #1;
    chk("mid_wb_valid", 64'(wb_valid), 64'd0);
    chk("mid_rf_wen", 64'(rf_wen), 64'd0);
    chk("mid_ready", 64'(req_ready), 64'd0);
    sb.delete();
    @(posedge clk);
    @(negedge clk);
    chk("mid_retire", retire_count, 64'd0);
    chk("mid_waddr", 64'(rf_waddr), 64'd0);
    chk("mid_wb_src", 64'(wb_src), 64'd0);
    req_valid = 4'b0000;
    rst = 1'b1;
    @(posedge clk);
    #1;
    step(4'b1111, 4'b0000, 0);
    step(4'b1111, 4'b0000, 1);
    step(4'b0000, 4'b0000, -1);
    step(4'b0000, 4'b0000, -1);
    chk("scoreboard_drained", 64'(sb.size()), 64'd0);
    chk("retire_after_restart", retire_count, 64'd2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
